// File: rtl/lsu_pkg.sv
// Shared LSU definitions: LStype codes, FSM states, byte-enable patterns.
// Alignment rules live here so the decoder and LSU agree on them.
package lsu_pkg;

    localparam logic [2:0] LS_W     = 3'b000;
    localparam logic [2:0] LS_H     = 3'b001;
    localparam logic [2:0] LS_HU_SB = 3'b010;
    localparam logic [2:0] LS_B     = 3'b011;
    localparam logic [2:0] LS_BU    = 3'b100;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_LO_H = 4'b0011;
    localparam logic [3:0] BE_HI_H = 4'b1100;
    localparam logic [3:0] BE_B0   = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_ERR  = 2'd3
    } lsu_state_t;

    // LS_HU_SB means lhu for loads but sb for stores.
    function automatic logic lsu_misaligned(
        input logic       we,
        input logic [2:0] ty,
        input logic [1:0] off
    );
        logic bad;
        bad = (off != 2'b00);
        if (we) begin
            case (ty)
                LS_H:     bad = off[0];
                LS_HU_SB: bad = 1'b0;
                default:  bad = (off != 2'b00);
            endcase
        end else begin
            case (ty)
                LS_H, LS_HU_SB: bad = off[0];
                LS_B, LS_BU:    bad = 1'b0;
                default:        bad = (off != 2'b00);
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
// One request/acknowledge transaction per access.
interface lsu_mem_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_lane_fmt.sv
// Byte-lane steering: store be/wdata replication and load
// extraction with sign/zero extension.
module lsu_lane_fmt
    import lsu_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  lstype_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    always_comb begin
        b_sel = rdata_i[7:0];
        case (off_i)
            2'd1:    b_sel = rdata_i[15:8];
            2'd2:    b_sel = rdata_i[23:16];
            2'd3:    b_sel = rdata_i[31:24];
            default: b_sel = rdata_i[7:0];
        endcase
        h_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = BE_ALL;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        if (we_i) begin
            case (lstype_i)
                LS_H: begin
                    be_o    = off_i[1] ? BE_HI_H : BE_LO_H;
                    wdata_o = {2{wdata_i[15:0]}};
                end
                LS_HU_SB: begin
                    be_o    = BE_B0 << off_i;
                    wdata_o = {4{wdata_i[7:0]}};
                end
                default: begin
                    be_o    = BE_ALL;
                    wdata_o = wdata_i;
                end
            endcase
        end else begin
            case (lstype_i)
                LS_H:     rdata_o = {{16{h_sel[15]}}, h_sel};
                LS_HU_SB: rdata_o = {16'h0000, h_sel};
                LS_B:     rdata_o = {{24{b_sel[7]}}, b_sel};
                LS_BU:    rdata_o = {24'h000000, b_sel};
                default:  rdata_o = rdata_i;
            endcase
        end
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit FSM between the MEM stage and the data bus.
// Optional alignment trap: define LSU_ALIGN_CHECK_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lsu_valid,
    input  logic          MemWrite,
    input  logic [2:0]    LStype,
    input  logic [AW-1:0] lsu_addr,
    input  logic [DW-1:0] lsu_wdata,
    output logic [DW-1:0] lsu_rdata,
    output logic          lsu_done,
    output logic          lsu_busy,
    output logic          lsu_addr_err,
    lsu_mem_if.master     mem
);
    lsu_state_t    state_q;
    logic          req_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          done_q;
    logic          busy_q;
    logic [2:0]    ls_q;
    logic [1:0]    off_q;

    logic          idle;
    logic          fmt_we;
    logic [2:0]    fmt_ty;
    logic [1:0]    fmt_off;
    logic [3:0]    fmt_be;
    logic [DW-1:0] fmt_wdata;
    logic [DW-1:0] fmt_rdata;

    // Store side is used at acceptance, load side on the ack edge.
    assign idle    = (state_q == S_IDLE);
    assign fmt_we  = idle ? MemWrite       : we_q;
    assign fmt_ty  = idle ? LStype         : ls_q;
    assign fmt_off = idle ? lsu_addr[1:0]  : off_q;

    lsu_lane_fmt u_fmt (
        .we_i     (fmt_we),
        .lstype_i (fmt_ty),
        .off_i    (fmt_off),
        .wdata_i  (lsu_wdata),
        .rdata_i  (mem.mem_rdata),
        .be_o     (fmt_be),
        .wdata_o  (fmt_wdata),
        .rdata_o  (fmt_rdata)
    );

`ifdef LSU_ALIGN_CHECK_EN
    logic err_q;
    logic misaligned_d;
    assign misaligned_d = lsu_misaligned(MemWrite, LStype, lsu_addr[1:0]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= BE_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ls_q    <= LS_W;
            off_q   <= 2'b00;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (lsu_valid) begin
                        ls_q   <= LStype;
                        off_q  <= lsu_addr[1:0];
                        busy_q <= 1'b1;
`ifdef LSU_ALIGN_CHECK_EN
                        if (misaligned_d) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else
`endif
                        begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            we_q    <= MemWrite;
                            be_q    <= fmt_be;
                            addr_q  <= {lsu_addr[AW-1:2], 2'b00};
                            wdata_q <= fmt_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        state_q <= S_RESP;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        rdata_q <= we_q ? '0 : fmt_rdata;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
`ifdef LSU_ALIGN_CHECK_EN
                S_ERR: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;

    assign lsu_rdata = rdata_q;
    assign lsu_done  = done_q;
    assign lsu_busy  = busy_q;
`ifdef LSU_ALIGN_CHECK_EN
    assign lsu_addr_err = err_q;
`else
    assign lsu_addr_err = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a completion scoreboard.
// Covers both builds of LSU_ALIGN_CHECK_EN.
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_valid = 1'b0;
    logic        MemWrite = 1'b0;
    logic [2:0]  LStype = 3'b000;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [31:0] lsu_rdata;
    logic        lsu_done;
    logic        lsu_busy;
    logic        lsu_addr_err;

    lsu_mem_if #(.AW(32), .DW(32)) bus ();

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lsu_valid    (lsu_valid),
        .MemWrite     (MemWrite),
        .LStype       (LStype),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .lsu_rdata    (lsu_rdata),
        .lsu_done     (lsu_done),
        .lsu_busy     (lsu_busy),
        .lsu_addr_err (lsu_addr_err),
        .mem          (bus.master)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the LSU idle.
    task automatic access(
        input string       tag,
        input logic        we,
        input logic [2:0]  ty,
        input logic [31:0] a,
        input logic [31:0] wd,
        input logic [31:0] rd,
        input int          waits,
        input logic [3:0]  xbe,
        input logic [31:0] xaddr,
        input logic [31:0] xwdata,
        input logic [31:0] xrd,
        input logic        xerr
    );
        exp_t e;
        exp_t g;
        int   busy_n;
        int   done_n;
        int   req_n;
        int   w;
        busy_n = 0;
        done_n = 0;
        req_n  = 0;
        w      = waits;
        e.rdata = xrd;
        e.err   = xerr;
        sbq.push_back(e);
        lsu_valid = 1'b1;
        MemWrite  = we;
        LStype    = ty;
        lsu_addr  = a;
        lsu_wdata = wd;
        bus.mem_rdata = rd;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            lsu_valid   = 1'b0;
            bus.mem_ack = 1'b0;
            if (lsu_busy) busy_n++;
            if (bus.mem_req) begin
                req_n++;
                chk({tag, ".we"}, 32'(bus.mem_we), 32'(we));
                chk({tag, ".be"}, 32'(bus.mem_be), 32'(xbe));
                chk({tag, ".addr"}, bus.mem_addr, xaddr);
                if (we) chk({tag, ".wdata"}, bus.mem_wdata, xwdata);
                if (w == 0) bus.mem_ack = 1'b1;
                else w--;
            end
            if (lsu_done) begin
                done_n++;
                if (sbq.size() == 0) begin
                    chk({tag, ".spurious_done"}, 32'(lsu_done), 32'd0);
                end else begin
                    g = sbq.pop_front();
                    chk({tag, ".err"}, 32'(lsu_addr_err), 32'(g.err));
                    if (!g.err) chk({tag, ".rdata"}, lsu_rdata, g.rdata);
                end
            end
            if (!lsu_busy && !lsu_done) break;
        end
        chk({tag, ".done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, ".busy_cycles"}, 32'(busy_n),
            xerr ? 32'd1 : 32'(waits + 2));
        chk({tag, ".req_cycles"}, 32'(req_n),
            xerr ? 32'd0 : 32'(waits + 1));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, ".we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, ".be"}, 32'(bus.mem_be), 32'd0);
        chk({tag, ".addr"}, bus.mem_addr, 32'd0);
        chk({tag, ".wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, ".rdata"}, lsu_rdata, 32'd0);
        chk({tag, ".done"}, 32'(lsu_done), 32'd0);
        chk({tag, ".busy"}, 32'(lsu_busy), 32'd0);
        chk({tag, ".err"}, 32'(lsu_addr_err), 32'd0);
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #2;
        chk_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        access("sw", 1'b1, 3'b000, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0,
               4'b1111, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("sb3", 1'b1, 3'b010, 32'h0000_0013, 32'h0000_00A5, 32'h0, 0,
               4'b1000, 32'h0000_0010, 32'hA5A5_A5A5, 32'h0, 1'b0);
        access("sb1", 1'b1, 3'b010, 32'h0000_0101, 32'h1234_5677, 32'h0, 1,
               4'b0010, 32'h0000_0100, 32'h7777_7777, 32'h0, 1'b0);
        access("sh2", 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 0,
               4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 32'h0, 1'b0);
        access("s111", 1'b1, 3'b111, 32'h0000_0308, 32'h0BAD_F00D, 32'h0, 0,
               4'b1111, 32'h0000_0308, 32'h0BAD_F00D, 32'h0, 1'b0);
        access("lb", 1'b0, 3'b011, 32'h0000_0002, 32'h0, 32'h1280_3456, 0,
               4'b1111, 32'h0000_0000, 32'h0, 32'hFFFF_FF80, 1'b0);
        access("lbu", 1'b0, 3'b100, 32'h0000_0002, 32'h0, 32'h1280_3456, 0,
               4'b1111, 32'h0000_0000, 32'h0, 32'h0000_0080, 1'b0);
        access("lb3", 1'b0, 3'b011, 32'h0000_0003, 32'h0, 32'h7F80_3456, 0,
               4'b1111, 32'h0000_0000, 32'h0, 32'h0000_007F, 1'b0);
        access("lh_w3", 1'b0, 3'b001, 32'h0000_0002, 32'h0, 32'h8001_0000, 3,
               4'b1111, 32'h0000_0000, 32'h0, 32'hFFFF_8001, 1'b0);
        access("lhu", 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1234_F00D, 0,
               4'b1111, 32'h0000_0040, 32'h0, 32'h0000_F00D, 1'b0);
        access("lw_w1", 1'b0, 3'b000, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1,
               4'b1111, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
        access("lw_mis", 1'b0, 3'b000, 32'h0000_0006, 32'h0, 32'h1111_2222, 0,
               4'b1111, 32'h0000_0004, 32'h0, 32'h0, 1'b1);
        access("sh_mis", 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 0,
               4'b0011, 32'h0000_0000, 32'hBEEF_BEEF, 32'h0, 1'b1);
`else
        access("lw_trunc", 1'b0, 3'b000, 32'h0000_0006, 32'h0, 32'h1111_2222, 0,
               4'b1111, 32'h0000_0004, 32'h0, 32'h1111_2222, 1'b0);
        access("sh_trunc", 1'b1, 3'b001, 32'h0000_0001, 32'h0000_BEEF, 32'h0, 0,
               4'b0011, 32'h0000_0000, 32'hBEEF_BEEF, 32'h0, 1'b0);
`endif

        // Ack outside REQ must not start or finish anything.
        bus.mem_ack = 1'b1;
        @(negedge clk);
        chk("stray_ack.done", 32'(lsu_done), 32'd0);
        chk("stray_ack.busy", 32'(lsu_busy), 32'd0);
        chk("stray_ack.req", 32'(bus.mem_req), 32'd0);
        bus.mem_ack = 1'b0;

        // Reset while the request is outstanding.
        lsu_valid = 1'b1;
        MemWrite  = 1'b0;
        LStype    = 3'b000;
        lsu_addr  = 32'h0000_0020;
        @(negedge clk);
        lsu_valid = 1'b0;
        chk("midreq.req_before", 32'(bus.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_quiet("midreq_rst");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access("lw_after_rst", 1'b0, 3'b000, 32'h0000_0024, 32'h0,
               32'h5A5A_1234, 0, 4'b1111, 32'h0000_0024, 32'h0,
               32'h5A5A_1234, 1'b0);

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store unit sitting between the MEM stage and the data-memory bus. It consumes the decoder's `MemWrite`/`LStype` control together with the effective address and store data. It runs one request/acknowledge transaction per access with byte-lane enables, then returns a sign- or zero-extended load result. While a transaction is outstanding it asserts `lsu_busy`, which the hazard logic uses to stall the pipeline.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width, fixed at 32 (four byte lanes).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `lsu_valid` input 1: MEM-stage access request, sampled only in IDLE.
- `MemWrite` input 1: 1 = store, 0 = load.
- `LStype` input 3: access size/extension (encoding under Operation).
- `lsu_addr` input AW: effective byte address.
- `lsu_wdata` input DW: store data, right-aligned.
- `lsu_rdata` output DW: formatted load result, valid while `lsu_done`=1.
- `lsu_done` output 1: one-cycle completion pulse.
- `lsu_busy` output 1: high whenever the state is not IDLE.
- `lsu_addr_err` output 1: misalignment flag, pulses together with `lsu_done`.
- `mem_req` output 1: bus request.
- `mem_we` output 1: bus write enable.
- `mem_be` output 4: byte enables.
- `mem_addr` output AW: word address; bits [1:0] are forced to 0.
- `mem_wdata` output DW: lane-replicated store data.
- `mem_rdata` input DW: bus read data, valid when `mem_ack`=1.
- `mem_ack` input 1: bus acknowledge.

## Operation
- `LStype` encoding for loads:
  - 000: lw
  - 001: lh
  - 010: lhu
  - 011: lb
  - 100: lbu
- `LStype` encoding for stores:
  - 000: sw
  - 001: sh
  - 010: sb
  - any other value: treat as sw.
- Store lanes:
  - sw: `mem_be`=1111, data passed through unchanged.
  - sh: `mem_be`=0011 when addr[1]=0, 1100 when addr[1]=1; wdata[15:0] replicated to both halves.
  - sb: `mem_be`=0001<<addr[1:0]; wdata[7:0] replicated to all four lanes.
- Loads drive `mem_be`=1111. The selected byte or half of `mem_rdata` is shifted down, then sign-extended (lb, lh) or zero-extended (lbu, lhu).
- State machine states: IDLE, REQ, RESP, ERR.
  - IDLE to REQ: `lsu_valid` is high and the access is aligned (or the alignment check is compiled out). `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are registered on this edge.
  - IDLE to ERR: `lsu_valid` is high and the access is misaligned (alignment check compiled in only).
  - REQ: `mem_req`=1 and all bus outputs are held stable until `mem_ack`=1. On the ack edge, `mem_rdata` is captured and formatted, then the state moves to RESP.
  - RESP: `lsu_done`=1 for one cycle and `lsu_rdata` is valid; then IDLE.
  - ERR: `lsu_done`=1 and `lsu_addr_err`=1 for one cycle; no bus request is issued; then IDLE.
- `lsu_valid` is ignored outside IDLE. The pipeline must hold its inputs stable while `lsu_busy`=1.
- For stores, `lsu_rdata`=0 in RESP.
- `mem_ack` is ignored outside REQ.
- Reset values: state = IDLE; all outputs 0, including `mem_be`, `mem_addr`, `mem_wdata` and `lsu_rdata`.
- Reset asserted mid-transaction: `mem_req` drops asynchronously and the access is abandoned. The memory side must tolerate a withdrawn request.

## Timing
- Input sampled at edge 0; `mem_req` high in cycle 1.
- Ack in cycle 1 (zero wait states) gives `lsu_done` in cycle 2, so best-case latency is 2 cycles. Each wait state adds 1 cycle.
- A misaligned access gives `lsu_done` with `lsu_addr_err` in cycle 1.
- Back-to-back: the earliest next `lsu_valid` acceptance is the cycle after RESP or ERR.
- `lsu_busy` is registered (state != IDLE) with no combinational path from `lsu_valid`.
- All outputs are registered; `lsu_rdata` comes from the capture register.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Word accesses with addr[1:0]≠0 and half accesses with addr[0]=1 go to ERR.
- `LSU_ALIGN_CHECK_EN` undefined:
  - There is no ERR state and `lsu_addr_err` is tied to 0.
  - Word access ignores addr[1:0]; half access ignores addr[0]. Lane selection uses the truncated address.

## Structure
- `lsu_pkg` holds:
  - `LStype` constants (`LS_W`, `LS_H`, `LS_HU_SB`, `LS_B`, `LS_BU`), shared with the instruction decoder.
  - The state enum `lsu_state_t`.
  - Byte-enable constants.
- One combinational sub-module, `lsu_lane_fmt`. It produces store-side `be` and `wdata` from (`LStype`, addr[1:0], wdata), and load-side extraction/extension from (`LStype`, addr[1:0], rdata).
- The FSM and the registers live in `lsu_mem_ctrl`.

## Test plan
- sw: addr 0x1000_0004, wdata 0xDEADBEEF, ack in cycle 1 -> `mem_we`=1, `mem_be`=1111, `mem_addr`=0x1000_0004, `lsu_done` in cycle 2.
- sb: addr 0x0000_0013, wdata 0x0000_00A5 -> `mem_be`=1000, `mem_wdata`=0xA5A5A5A5, `mem_addr`=0x0000_0010.
- lb and lbu: addr 0x0000_0002, `mem_rdata`=0x1280_3456 -> lb gives 0xFFFF_FF80; lbu gives 0x0000_0080.
- lh with 3 wait states: addr 0x0000_0002, `mem_rdata`=0x8001_0000 -> `lsu_busy` high for 5 cycles, `lsu_rdata`=0xFFFF_8001, `lsu_done` pulses once.
- lw at 0x0000_0006 with `LSU_ALIGN_CHECK_EN`:
  - `lsu_addr_err` and `lsu_done` in cycle 1, `mem_req` never asserted.
  - Without the macro: `mem_addr`=0x0000_0004 and a normal completion.
- Reset mid-REQ: `rst_n` low while `mem_req`=1 -> `mem_req` drops without waiting for a clock edge, all outputs 0. After release, a new lw completes normally.
